// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
package mem_arb_pkg;

   localparam int DEF_AW = 16;
   localparam int DEF_DW = 16;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      WAIT  = ST_WAIT
   } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// One master's command/response port into the memory arbiter.
interface mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   // Handshake: master raises req with we/addr/wdata and holds them until it
   // sees gnt (a one-cycle pulse meaning the command reached memory); a read
   // later returns a one-cycle rvalid, and rdata holds until that port's next read.
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arb_pick.sv
// Fixed-priority pick (CPU first) with a starvation counter that forces
// the aux port through after MAX_HOLD consecutive CPU wins.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic take,
   input  logic req0,
   input  logic req1,
   output logic winner,
   output logic valid
);

   localparam logic [3:0] HOLD = 4'(MAX_HOLD);

   logic [3:0] starve_cnt;

   always_comb begin
      valid  = en & (req0 | req1);
      winner = (req1 && (!req0 || starve_cnt == HOLD)) ? PORT_AUX : PORT_CPU;
   end

   // Counter only moves on IDLE cycles; it tracks CPU wins made over a waiting aux.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (take) begin
         if (!req1) begin
            starve_cnt <= '0;
         end else if (valid) begin
            if (winner == PORT_AUX) starve_cnt <= '0;
            else if (starve_cnt != HOLD) starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU (p0) and aux (p1) accesses onto the single main memory,
// one access outstanding at a time.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int RD_LAT   = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   mem_arbiter_if.slave  p0,
   mem_arbiter_if.slave  p1,
   output logic          mem_en,
   output logic          mem_rw,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   output logic          busy,
   output state_e        state_dbg
);

   localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

   logic [1:0]    state;
   logic          win;
   logic [1:0]    wait_cnt;
   logic          rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic          pick_winner, pick_valid;

   mem_arb_pick #(.MAX_HOLD(MAX_HOLD)) u_pick (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .take   (state == ST_IDLE),
      .req0   (p0.req),
      .req1   (p1.req),
      .winner (pick_winner),
      .valid  (pick_valid)
   );

   // Combinational from state so an asynchronous reset drops mem_en at once.
   assign mem_en    = (state == ST_ISSUE);
   assign busy      = (state != ST_IDLE);
   assign state_dbg = state_e'(state);

   assign p0.gnt    = mem_en & (win == PORT_CPU);
   assign p1.gnt    = mem_en & (win == PORT_AUX);
   assign p0.rvalid = rvalid0;
   assign p1.rvalid = rvalid1;
   assign p0.rdata  = rdata0;
   assign p1.rdata  = rdata1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         win      <= PORT_CPU;
         wait_cnt <= '0;
         mem_rw   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         rdata0   <= '0;
         rdata1   <= '0;
         rvalid0  <= 1'b0;
         rvalid1  <= 1'b0;
      end else begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  state <= ST_ISSUE;
                  win   <= pick_winner;
                  if (pick_winner == PORT_AUX) begin
                     mem_rw   <= p1.we;
                     mem_addr <= p1.addr;
                     mem_din  <= p1.wdata;
                  end else begin
                     mem_rw   <= p0.we;
                     mem_addr <= p0.addr;
                     mem_din  <= p0.wdata;
                  end
               end
            end
            ST_ISSUE: begin
               wait_cnt <= '0;
               state    <= mem_rw ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_cnt == LAST_WAIT) begin
                  state <= ST_IDLE;
                  if (win == PORT_AUX) begin
                     rdata1  <= mem_dout;
                     rvalid1 <= 1'b1;
                  end else begin
                     rdata0  <= mem_dout;
                     rvalid0 <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized two-port traffic
// checked against a transaction-level model of priority, starvation and memory contents.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int RD_LAT = 1;
   localparam int MAX_HOLD = 4;
   localparam int TMO = 200;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en  = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- main DUT (RD_LAT=1) ----------------
   mem_arbiter_if #(.AW(AW), .DW(DW)) p0 ();
   mem_arbiter_if #(.AW(AW), .DW(DW)) p1 ();
   logic          mem_en, mem_rw, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din, mem_dout, rd_pipe;
   state_e        state_dbg;

   mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst), .en(en), .p0(p0), .p1(p1),
      .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .busy(busy), .state_dbg(state_dbg)
   );

   logic [DW-1:0] mem [0:8191];
   assign mem_dout = rd_pipe;
   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = '0;
      rd_pipe <= '0;
      forever begin
         @(posedge clk);
         if (mem_en && !mem_rw) rd_pipe <= mem[mem_addr[12:0]];
         if (mem_en && mem_rw) mem[mem_addr[12:0]] = mem_din;
      end
   end

   // ---------------- second DUT (RD_LAT=3) ----------------
   mem_arbiter_if #(.AW(AW), .DW(DW)) q0 ();
   mem_arbiter_if #(.AW(AW), .DW(DW)) q1 ();
   logic          mem_en3, mem_rw3, busy3;
   logic [AW-1:0] mem_addr3;
   logic [DW-1:0] mem_din3, mem_dout3;
   logic [DW-1:0] pipe3 [0:2];
   state_e        state_dbg3;

   mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .MAX_HOLD(MAX_HOLD)) dut3 (
      .clk(clk), .rst(rst), .en(en), .p0(q0), .p1(q1),
      .mem_en(mem_en3), .mem_rw(mem_rw3), .mem_addr(mem_addr3), .mem_din(mem_din3),
      .mem_dout(mem_dout3), .busy(busy3), .state_dbg(state_dbg3)
   );

   assign mem_dout3 = pipe3[2];
   initial begin
      for (int i = 0; i < 3; i++) pipe3[i] <= '0;
      forever begin
         @(posedge clk);
         pipe3[0] <= (mem_en3 && !mem_rw3) ? (mem_addr3 ^ 16'h5A5A) : pipe3[0];
         pipe3[1] <= pipe3[0];
         pipe3[2] <= pipe3[1];
      end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   logic [DW-1:0] shadow [0:8191];
   logic [DW-1:0] exp_q0[$], exp_q1[$];
   int            exp_t0[$], exp_t1[$];
   logic          grant_log[$];
   bit            mon_on = 1'b0;
   bit            prev_r0, prev_r1;
   int            streak = 0;
   int            next_free = 0;
   int            gnt1_cnt = 0;
   logic [DW-1:0] last_rd0 = '0;

   initial begin
      logic g0, g1, r0, r1, ew, cw;
      logic [AW-1:0] ca;
      logic [DW-1:0] cd, ed;
      for (int i = 0; i < 8192; i++) shadow[i] = '0;
      prev_r0 = 1'b0;
      prev_r1 = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_r0 = 1'b0;
            prev_r1 = 1'b0;
         end else if (mon_on) begin
            g0 = p0.gnt;
            g1 = p1.gnt;
            if (g1) gnt1_cnt++;
            if (g0 || g1 || mem_en) check_eq("mem_en_vs_gnt", mem_en, g0 | g1);
            if (g0 || g1) begin
               check_eq("gnt_onehot", 32'(g0) + 32'(g1), 1);
               check_eq("gnt_had_req", prev_r0 | prev_r1, 1);
               check_eq("gnt_spacing", cyc >= next_free, 1);
               // CPU has priority unless aux has waited through MAX_HOLD CPU wins.
               if (prev_r0 && prev_r1) ew = (streak == MAX_HOLD);
               else ew = prev_r1;
               check_eq("winner", g1, ew);
               grant_log.push_back(g1);
               if (!prev_r1) streak = 0;
               else if (ew) streak = 0;
               else if (streak < MAX_HOLD) streak++;
               cw = ew ? p1.we : p0.we;
               ca = ew ? p1.addr : p0.addr;
               cd = ew ? p1.wdata : p0.wdata;
               check_eq("mem_rw", mem_rw, cw);
               check_eq("mem_addr", mem_addr, ca);
               if (cw) begin
                  check_eq("mem_din", mem_din, cd);
                  shadow[ca[12:0]] = cd;
                  next_free = cyc + 2;
               end else begin
                  if (ew) begin exp_q1.push_back(shadow[ca[12:0]]); exp_t1.push_back(cyc + RD_LAT + 1); end
                  else    begin exp_q0.push_back(shadow[ca[12:0]]); exp_t0.push_back(cyc + RD_LAT + 1); end
                  next_free = cyc + RD_LAT + 2;
               end
            end
            r0 = p0.rvalid;
            r1 = p1.rvalid;
            if (r0 || r1) check_eq("rvalid_onehot", 32'(r0) + 32'(r1), 1);
            if (r0) begin
               check_eq("rvalid0_pending", exp_q0.size() > 0, 1);
               if (exp_q0.size() > 0) begin
                  ed = exp_q0.pop_front();
                  last_rd0 = ed;
                  check_eq("rdata0", p0.rdata, ed);
                  check_eq("rvalid0_cycle", cyc, exp_t0.pop_front());
               end
            end
            if (r1) begin
               check_eq("rvalid1_pending", exp_q1.size() > 0, 1);
               if (exp_q1.size() > 0) begin
                  check_eq("rdata1", p1.rdata, exp_q1.pop_front());
                  check_eq("rvalid1_cycle", cyc, exp_t1.pop_front());
               end
            end
            prev_r0 = p0.req && en;
            prev_r1 = p1.req && en;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 of the cycle after gnt.
   task automatic access(input bit p, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int rcyc, output int gcyc);
      logic g;
      rcyc = cyc;
      gcyc = -1;
      if (p) begin p1.req = 1'b1; p1.we = we; p1.addr = a; p1.wdata = d; end
      else   begin p0.req = 1'b1; p0.we = we; p0.addr = a; p0.wdata = d; end
      for (int n = 0; n < TMO; n++) begin
         @(negedge clk);
         g = p ? p1.gnt : p0.gnt;
         if (g === 1'b1) begin
            gcyc = cyc;
            break;
         end
      end
      if (gcyc < 0) check_eq(p ? "gnt1_timeout" : "gnt0_timeout", 32'(gcyc), 32'(rcyc + 1));
      @(posedge clk);
      #1;
      if (p) p1.req = 1'b0;
      else   p0.req = 1'b0;
   endtask

   task automatic wait_rvalid(input bit p, output int t);
      logic v;
      t = -1;
      for (int n = 0; n < TMO; n++) begin
         @(negedge clk);
         v = p ? p1.rvalid : p0.rvalid;
         if (v === 1'b1) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) check_eq(p ? "rvalid1_timeout" : "rvalid0_timeout", 32'(t), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_port(input bit p, input int count);
      int r, g;
      logic [AW-1:0] a;
      for (int k = 0; k < count; k++) begin
         a = ($urandom_range(0, 7) == 0) ? 16'h1FFF : 16'($urandom_range(0, 15));
         access(p, 1'($urandom_range(0, 1)), a, 16'($urandom), r, g);
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
   endtask

   // ---------------- stimulus ----------------
   int rc, gc, t, n3, g3, t3, en_cnt, snap, e_cyc, g1r, g1g;
   bit exp_order [10];

   initial begin
      exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      p0.req = 0; p0.we = 0; p0.addr = '0; p0.wdata = '0;
      p1.req = 0; p1.we = 0; p1.addr = '0; p1.wdata = '0;
      q0.req = 0; q0.we = 0; q0.addr = '0; q0.wdata = '0;
      q1.req = 0; q1.we = 0; q1.addr = '0; q1.wdata = '0;

      // reset values
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_mem_en", mem_en, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_gnt", {p0.gnt, p1.gnt}, 0);
      check_eq("rst_rvalid", {p0.rvalid, p1.rvalid}, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_din", mem_din, 0);
      check_eq("rst_mem_rw", mem_rw, 0);
      check_eq("rst_rdata", {p0.rdata, p1.rdata}, 0);
      check_eq("rst_state", state_dbg, IDLE);
      rst = 1'b1;
      en = 1'b1;
      mon_on = 1'b1;
      @(posedge clk);
      #1;

      // single write then read on port 0
      access(0, 1, 16'h0010, 16'h1234, rc, gc);
      check_eq("wr0_gnt_lat", gc - rc, 1);
      access(0, 0, 16'h0010, 16'h0000, rc, gc);
      check_eq("rd0_gnt_lat", gc - rc, 1);
      wait_rvalid(0, t);
      check_eq("rd0_rvalid_lat", t - rc, 3);
      check_eq("rd0_rdata", p0.rdata, 16'h1234);
      check_eq("no_gnt1_t1", gnt1_cnt, 0);

      // RD_LAT=3 build
      n3 = cyc; g3 = -1; t3 = -1; en_cnt = 0;
      q0.req = 1'b1; q0.we = 1'b0; q0.addr = 16'h0AAA;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_en3) en_cnt++;
         if (q0.gnt && g3 < 0) begin g3 = cyc; q0.req = 1'b0; end
         if (q0.rvalid) begin t3 = cyc; break; end
      end
      repeat (3) begin @(negedge clk); if (mem_en3) en_cnt++; end
      check_eq("lat3_gnt", g3 - n3, 1);
      check_eq("lat3_rvalid", t3 - n3, 5);
      check_eq("lat3_rdata", q0.rdata, 16'h50F0);
      check_eq("lat3_mem_en_cycles", en_cnt, 1);
      check_eq("lat3_idle", state_dbg3, IDLE);
      @(posedge clk);
      #1;

      // simultaneous reads, starvation guard
      grant_log.delete();
      fork
         begin
            for (int k = 0; k < 8; k++) access(0, 0, 16'($urandom_range(0, 31)), 0, rc, gc);
         end
         begin
            for (int k = 0; k < 2; k++) access(1, 0, 16'($urandom_range(0, 31)), 0, rc, gc);
         end
      join
      repeat (6) @(posedge clk);
      #1;
      check_eq("order_len", grant_log.size(), 10);
      for (int k = 0; k < 10; k++)
         if (k < grant_log.size()) check_eq($sformatf("order_%0d", k), grant_log[k], exp_order[k]);

      // port 1 alone
      snap = 32'(last_rd0);
      access(1, 1, 16'h1FFF, 16'hBEEF, rc, gc);
      access(1, 0, 16'h1FFF, 16'h0000, rc, gc);
      wait_rvalid(1, t);
      check_eq("p1_rdata", p1.rdata, 16'hBEEF);
      check_eq("p1_rvalid_lat", t - rc, 3);
      check_eq("p0_rdata_held", p0.rdata, snap);

      // global enable low during WAIT
      access(0, 0, 16'h0010, 16'h0000, rc, gc);
      en = 1'b0;
      fork
         access(1, 1, 16'h0020, 16'hCAFE, g1r, g1g);
      join_none
      wait_rvalid(0, t);
      check_eq("en0_rvalid_lat", t - rc, 3);
      check_eq("en0_rdata", p0.rdata, 16'h1234);
      snap = gnt1_cnt;
      repeat (5) @(posedge clk);
      #1;
      check_eq("en0_no_gnt1", gnt1_cnt, snap);
      e_cyc = cyc;
      en = 1'b1;
      wait fork;
      check_eq("en1_gnt1_lat", g1g - e_cyc, 1);

      // reset during WAIT of a read
      access(0, 0, 16'h0010, 16'h0000, rc, gc);
      #1;
      check_eq("pre_rst_busy", busy, 1);
      rst = 1'b0;
      mon_on = 1'b0;
      #1;
      check_eq("arst_mem_en", mem_en, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_rvalid0", p0.rvalid, 0);
      check_eq("arst_state", state_dbg, IDLE);
      check_eq("arst_rdata0", p0.rdata, 0);
      exp_q0.delete(); exp_t0.delete(); exp_q1.delete(); exp_t1.delete();
      streak = 0;
      next_free = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      mon_on = 1'b1;
      @(posedge clk);
      #1;
      access(0, 0, 16'h0010, 16'h0000, rc, gc);
      check_eq("post_rst_gnt_lat", gc - rc, 1);
      wait_rvalid(0, t);
      check_eq("post_rst_rvalid_lat", t - rc, 3);
      check_eq("post_rst_rdata", p0.rdata, 16'h1234);

      // randomized traffic on both ports
      fork
         rand_port(0, 30);
         rand_port(1, 30);
      join
      repeat (8) @(posedge clk);
      #1;
      check_eq("q0_drained", exp_q0.size(), 0);
      check_eq("q1_drained", exp_q1.size(), 0);
      check_eq("final_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
